debug_controller: RTL and testbench

Sequencer between the UART pair and the MIPS pipeline. It assembles received bytes into 32-bit instruction words and writes them into instruction memory. It then gates the pipeline enable in continuous-run or single-step mode, per host commands. After each run or step, it streams PC, cycle count and the full register bank back through the UART transmitter.

---
 rtl/debug_controller_if.sv | 27 ++
 rtl/debug_controller.sv | 236 +++++++++++++++++++++++
 tb/tb_debug_controller.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_controller_if.sv
// UART-side handshake bundle between the debug controller (master) and the
// UART receiver/transmitter pair (slave).
interface debug_controller_if #(
  parameter int N_BITS = 8
);
  logic              rx_done_tick_i;
  logic [N_BITS-1:0] rx_data_i;
  logic              tx_done_tick_i;
  logic              tx_start_o;
  logic [N_BITS-1:0] tx_data_o;

  modport master (
    input  rx_done_tick_i,
    input  rx_data_i,
    input  tx_done_tick_i,
    output tx_start_o,
    output tx_data_o
  );

  modport slave (
    output rx_done_tick_i,
    output rx_data_i,
    output tx_done_tick_i,
    input  tx_start_o,
    input  tx_data_o
  );
endinterface

// File: rtl/debug_controller.sv
// Debug sequencer between the UART pair and the MIPS pipeline.
// It assembles received bytes into instruction words and writes them to
// instruction memory. It then gates the pipeline enable for run or single-step
// commands. After each run or step it streams PC, cycle count and all 32
// registers back out, MSB first.
module debug_controller #(
  parameter int                NB_DATA      = 32,
  parameter int                ADDR_W       = 7,
  parameter int                N_BITS       = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD   = 32'hFFFFFFFF,
  parameter int                DRAIN_CYCLES = 4,
  parameter logic [N_BITS-1:0] CMD_RUN      = 8'h43,
  parameter logic [N_BITS-1:0] CMD_STEP     = 8'h53
) (
  input  logic                 clock,
  input  logic                 reset,
  debug_controller_if.master   uart,
  output logic                 inst_wr_en_o,
  output logic [ADDR_W-1:0]    inst_wr_addr_o,
  output logic [NB_DATA-1:0]   inst_wr_data_o,
  input  logic                 halt_i,
  input  logic [ADDR_W-1:0]    pc_i,
  output logic [4:0]           dbg_reg_addr_o,
  input  logic [NB_DATA-1:0]   reg_data_i,
  output logic                 en_pipeline_o,
  output logic                 program_loaded_o,
  output logic                 halted_o,
  output logic [3:0]           state_o
);

  typedef enum logic [3:0] {
    LOAD     = 4'd0,
    WRITE    = 4'd1,
    WAIT_CMD = 4'd2,
    RUN      = 4'd3,
    DRAIN    = 4'd4,
    STEP     = 4'd5,
    DUMP_PC  = 4'd6,
    DUMP_CNT = 4'd7,
    DUMP_REG = 4'd8,
    FINISHED = 4'd9
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'((2 ** ADDR_W) - 4);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(4);
  localparam logic [7:0]        DRAIN_LAST = 8'(DRAIN_CYCLES - 1);
  localparam logic [4:0]        LAST_REG   = 5'd31;

  state_t                       state_r;
  // Only the first three bytes need storing; the fourth goes straight to memory.
  logic [NB_DATA-N_BITS-1:0]    word_r;
  logic [1:0]                   rx_cnt_r;
  logic [ADDR_W-1:0]            addr_r;
  logic [31:0]                  cycle_cnt_r;
  logic [7:0]                   drain_cnt_r;
  logic [NB_DATA-1:0]           tx_shift_r;
  logic [1:0]                   tx_byte_r;
  logic                         tx_busy_r;
  logic                         reg_load_r;

  logic                         dump_state_s;
  logic                         byte_done_s;
  logic                         field_done_s;
  logic [NB_DATA-1:0]           pc_ext_s;

  assign state_o      = state_r;
  assign dump_state_s = (state_r == DUMP_PC) || (state_r == DUMP_CNT) || (state_r == DUMP_REG);
  // A done tick only counts while a byte is outstanding.
  assign byte_done_s  = tx_busy_r && uart.tx_done_tick_i;
  assign field_done_s = byte_done_s && (tx_byte_r == 2'd3);
  assign pc_ext_s     = {{(NB_DATA-ADDR_W){1'b0}}, pc_i};

  // Free-running count of enabled pipeline cycles; only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cycle_cnt_r <= 32'd0;
    end else begin
      cycle_cnt_r <= cycle_cnt_r + {31'd0, en_pipeline_o};
    end
  end

  // Main sequencer: load, command decode, pipeline gating and dump streaming.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r          <= LOAD;
      word_r           <= '0;
      rx_cnt_r         <= 2'd0;
      addr_r           <= '0;
      drain_cnt_r      <= 8'd0;
      tx_shift_r       <= '0;
      tx_byte_r        <= 2'd0;
      tx_busy_r        <= 1'b0;
      reg_load_r       <= 1'b0;
      uart.tx_start_o  <= 1'b0;
      uart.tx_data_o   <= '0;
      inst_wr_en_o     <= 1'b0;
      inst_wr_addr_o   <= '0;
      inst_wr_data_o   <= '0;
      dbg_reg_addr_o   <= 5'd0;
      en_pipeline_o    <= 1'b0;
      program_loaded_o <= 1'b0;
      halted_o         <= 1'b0;
    end else begin
      uart.tx_start_o <= 1'b0;

      // Byte-slot engine shared by the three dump states. The case below
      // overrides the shift register when a whole field has gone out.
      if (dump_state_s) begin
        if (byte_done_s) begin
          tx_busy_r  <= 1'b0;
          tx_shift_r <= tx_shift_r << N_BITS;
          tx_byte_r  <= tx_byte_r + 2'd1;
        end else if (!tx_busy_r && !reg_load_r) begin
          uart.tx_start_o <= 1'b1;
          uart.tx_data_o  <= tx_shift_r[NB_DATA-1 -: N_BITS];
          tx_busy_r       <= 1'b1;
        end
      end

      case (state_r)
        LOAD: begin
          if (uart.rx_done_tick_i) begin
            word_r   <= {word_r[NB_DATA-2*N_BITS-1:0], uart.rx_data_i};
            rx_cnt_r <= rx_cnt_r + 2'd1;
            if (rx_cnt_r == 2'd3) begin
              inst_wr_en_o   <= 1'b1;
              inst_wr_addr_o <= addr_r;
              inst_wr_data_o <= {word_r, uart.rx_data_i};
              state_r        <= WRITE;
            end
          end
        end

        WRITE: begin
          inst_wr_en_o <= 1'b0;
          addr_r       <= addr_r + ADDR_STEP;
          // The halt word itself is still written; loading stops afterwards.
          if ((inst_wr_data_o == HALT_WORD) || (inst_wr_addr_o == LAST_ADDR)) begin
            program_loaded_o <= 1'b1;
            state_r          <= WAIT_CMD;
          end else begin
            state_r <= LOAD;
          end
        end

        WAIT_CMD: begin
          if (uart.rx_done_tick_i) begin
            if (uart.rx_data_i == CMD_RUN) begin
              en_pipeline_o <= 1'b1;
              state_r       <= RUN;
            end else if (uart.rx_data_i == CMD_STEP) begin
              en_pipeline_o <= 1'b1;
              state_r       <= STEP;
            end else begin
              state_r <= WAIT_CMD;
            end
          end
        end

        RUN: begin
          // The halt cycle itself is enabled, then the pipeline drains.
          if (halt_i) begin
            drain_cnt_r <= 8'd0;
            state_r     <= DRAIN;
          end
        end

        DRAIN: begin
          if (drain_cnt_r == DRAIN_LAST) begin
            en_pipeline_o <= 1'b0;
            halted_o      <= 1'b1;
            tx_shift_r    <= pc_ext_s;
            tx_byte_r     <= 2'd0;
            reg_load_r    <= 1'b0;
            state_r       <= DUMP_PC;
          end else begin
            drain_cnt_r <= drain_cnt_r + 8'd1;
          end
        end

        STEP: begin
          if (halt_i) begin
            drain_cnt_r <= 8'd0;
            state_r     <= DRAIN;
          end else begin
            en_pipeline_o <= 1'b0;
            tx_shift_r    <= pc_ext_s;
            tx_byte_r     <= 2'd0;
            reg_load_r    <= 1'b0;
            state_r       <= DUMP_PC;
          end
        end

        DUMP_PC: begin
          if (field_done_s) begin
            tx_shift_r <= cycle_cnt_r;
            state_r    <= DUMP_CNT;
          end
        end

        DUMP_CNT: begin
          // Present register 0's address now; its data is sampled next cycle.
          if (field_done_s) begin
            dbg_reg_addr_o <= 5'd0;
            reg_load_r     <= 1'b1;
            state_r        <= DUMP_REG;
          end
        end

        DUMP_REG: begin
          if (reg_load_r) begin
            tx_shift_r <= reg_data_i;
            reg_load_r <= 1'b0;
          end else if (field_done_s) begin
            if (dbg_reg_addr_o == LAST_REG) begin
              dbg_reg_addr_o <= 5'd0;
              state_r        <= halted_o ? FINISHED : WAIT_CMD;
            end else begin
              dbg_reg_addr_o <= dbg_reg_addr_o + 5'd1;
              reg_load_r     <= 1'b1;
            end
          end
        end

        FINISHED: begin
          state_r <= FINISHED;
        end

        default: begin
          state_r <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller: load, step, run, dump and reset cases.
module tb_debug_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        halt_i = 1'b0;
  logic [6:0]  pc_i = 7'd0;
  logic [31:0] reg_data_i;
  logic        inst_wr_en_o;
  logic [6:0]  inst_wr_addr_o;
  logic [31:0] inst_wr_data_o;
  logic [4:0]  dbg_reg_addr_o;
  logic        en_pipeline_o;
  logic        program_loaded_o;
  logic        halted_o;
  logic [3:0]  state_o;

  int tests = 0;
  int fails = 0;
  int hold_err = 0;
  int dup_err = 0;
  logic [7:0] dump_q [0:135];

  debug_controller_if #(.N_BITS(8)) uart_bus ();

  debug_controller dut (
    .clock            (clock),
    .reset            (reset),
    .uart             (uart_bus),
    .inst_wr_en_o     (inst_wr_en_o),
    .inst_wr_addr_o   (inst_wr_addr_o),
    .inst_wr_data_o   (inst_wr_data_o),
    .halt_i           (halt_i),
    .pc_i             (pc_i),
    .dbg_reg_addr_o   (dbg_reg_addr_o),
    .reg_data_i       (reg_data_i),
    .en_pipeline_o    (en_pipeline_o),
    .program_loaded_o (program_loaded_o),
    .halted_o         (halted_o),
    .state_o          (state_o)
  );

  always #5 clock = ~clock;

  // Register bank stand-in: register k reads as k in every byte.
  assign reg_data_i = 32'h01010101 * {27'd0, dbg_reg_addr_o};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_bus.rx_data_i      = b;
    uart_bus.rx_done_tick_i = 1'b1;
    tick();
    uart_bus.rx_done_tick_i = 1'b0;
  endtask

  // Sends one word MSB first and checks the resulting write pulse.
  task automatic load_word(input logic [31:0] w, input logic [6:0] a,
                           input logic [3:0] next_state, input logic loaded);
    for (int b = 0; b < 4; b++) begin
      send_byte(w[31 - 8*b -: 8]);
      if (b < 3) tick();
    end
    check("wr_en_high", {31'd0, inst_wr_en_o}, 32'd1);
    check("wr_addr", {25'd0, inst_wr_addr_o}, {25'd0, a});
    check("wr_data", inst_wr_data_o, w);
    tick();
    check("wr_en_pulse_end", {31'd0, inst_wr_en_o}, 32'd0);
    check("after_write_state", {28'd0, state_o}, {28'd0, next_state});
    check("program_loaded", {31'd0, program_loaded_o}, {31'd0, loaded});
  endtask

  // UART transmitter model: records bytes, answers each with tx_done after delay cycles.
  task automatic collect(input int delay, input int limit, output int en_cnt, output int got);
    int n = 0;
    int wc = 0;
    int budget = 0;
    bit pend = 1'b0;
    en_cnt = 0;
    while ((n < limit || pend) && budget < 30000) begin
      uart_bus.tx_done_tick_i = 1'b0;
      if (en_pipeline_o) en_cnt++;
      if (uart_bus.tx_start_o) begin
        if (pend) dup_err++;
        if (n < 136) dump_q[n] = uart_bus.tx_data_o;
        n++;
        pend = 1'b1;
        wc = delay;
      end else if (pend) begin
        if (uart_bus.tx_data_o !== dump_q[n-1]) hold_err++;
        if (wc == 0) begin
          uart_bus.tx_done_tick_i = 1'b1;
          pend = 1'b0;
        end else begin
          wc--;
        end
      end
      tick();
      budget++;
    end
    uart_bus.tx_done_tick_i = 1'b0;
    got = n;
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [31:0] pcv, input logic [31:0] cv);
    logic [31:0] w;
    if (i < 4) w = pcv;
    else if (i < 8) w = cv;
    else w = 32'h01010101 * ((i - 8) / 4);
    return w[31 - 8*(i % 4) -: 8];
  endfunction

  function automatic int dump_mismatches(input int n, input logic [31:0] pcv, input logic [31:0] cv);
    int m = 0;
    for (int i = 0; i < n && i < 136; i++) begin
      if (dump_q[i] !== exp_byte(i, pcv, cv)) m++;
    end
    return m;
  endfunction

  initial begin
    int en_cnt;
    int en2;
    int got;
    int seen;
    uart_bus.rx_done_tick_i = 1'b0;
    uart_bus.rx_data_i      = 8'd0;
    uart_bus.tx_done_tick_i = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_state", {28'd0, state_o}, 32'd0);
    check("rst_tx_start", {31'd0, uart_bus.tx_start_o}, 32'd0);
    check("rst_tx_data", {24'd0, uart_bus.tx_data_o}, 32'd0);
    check("rst_wr_en", {31'd0, inst_wr_en_o}, 32'd0);
    check("rst_wr_addr", {25'd0, inst_wr_addr_o}, 32'd0);
    check("rst_wr_data", inst_wr_data_o, 32'd0);
    check("rst_dbg_addr", {27'd0, dbg_reg_addr_o}, 32'd0);
    check("rst_en", {31'd0, en_pipeline_o}, 32'd0);
    check("rst_loaded", {31'd0, program_loaded_o}, 32'd0);
    check("rst_halted", {31'd0, halted_o}, 32'd0);
    reset = 1'b1;
    tick();

    // Three-word program ending in the halt word
    load_word(32'h20010005, 7'd0, 4'd0, 1'b0);
    load_word(32'h20020003, 7'd4, 4'd0, 1'b0);
    load_word(32'hFFFFFFFF, 7'd8, 4'd2, 1'b1);

    // Unknown command byte is ignored
    send_byte(8'h00);
    tick();
    check("ignore_cmd_state", {28'd0, state_o}, 32'd2);
    check("ignore_cmd_en", {31'd0, en_pipeline_o}, 32'd0);

    // Single step, fast transmitter
    pc_i = 7'h0C;
    send_byte(8'h53);
    check("step_state", {28'd0, state_o}, 32'd5);
    check("step_en_rise", {31'd0, en_pipeline_o}, 32'd1);
    collect(0, 136, en_cnt, got);
    check("step1_en_cycles", en_cnt, 32'd1);
    check("step1_len", got, 32'd136);
    check("step1_pc", {dump_q[0], dump_q[1], dump_q[2], dump_q[3]}, 32'h0000000C);
    check("step1_cnt", {dump_q[4], dump_q[5], dump_q[6], dump_q[7]}, 32'h00000001);
    check("step1_reg5", {dump_q[28], dump_q[29], dump_q[30], dump_q[31]}, 32'h05050505);
    check("step1_all_bytes", dump_mismatches(got, 32'h0000000C, 32'h1), 32'd0);
    check("step1_back_wait", {28'd0, state_o}, 32'd2);
    check("step1_halted", {31'd0, halted_o}, 32'd0);

    // Single step, transmitter stalled 100 cycles per byte
    pc_i = 7'h10;
    send_byte(8'h53);
    collect(100, 136, en_cnt, got);
    check("step2_en_cycles", en_cnt, 32'd1);
    check("step2_len", got, 32'd136);
    check("step2_cnt", {dump_q[4], dump_q[5], dump_q[6], dump_q[7]}, 32'h00000002);
    check("step2_reg31", {dump_q[132], dump_q[133], dump_q[134], dump_q[135]}, 32'h1F1F1F1F);
    check("step2_all_bytes", dump_mismatches(got, 32'h00000010, 32'h2), 32'd0);
    check("tx_data_held", hold_err, 32'd0);
    check("tx_no_dup_start", dup_err, 32'd0);
    check("step2_back_wait", {28'd0, state_o}, 32'd2);

    // Third step, reset in the middle of the register dump
    pc_i = 7'h14;
    send_byte(8'h53);
    collect(0, 20, en_cnt, got);
    check("step3_partial_len", got, 32'd20);
    check("step3_partial_bytes", dump_mismatches(got, 32'h00000014, 32'h3), 32'd0);
    check("step3_in_dump_reg", {28'd0, state_o}, 32'd8);
    check("step3_dbg_addr", {27'd0, dbg_reg_addr_o}, 32'd3);
    #2 reset = 1'b0;
    #1;
    check("mid_dump_rst_state", {28'd0, state_o}, 32'd0);
    check("mid_dump_rst_dbg", {27'd0, dbg_reg_addr_o}, 32'd0);
    check("mid_dump_rst_loaded", {31'd0, program_loaded_o}, 32'd0);
    check("mid_dump_rst_wr_data", inst_wr_data_o, 32'd0);
    check("mid_dump_rst_wr_addr", {25'd0, inst_wr_addr_o}, 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // Reset while the second load byte is arriving
    send_byte(8'hDE);
    tick();
    uart_bus.rx_data_i      = 8'hAD;
    uart_bus.rx_done_tick_i = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("mid_load_rst_state", {28'd0, state_o}, 32'd0);
    check("mid_load_rst_wr_en", {31'd0, inst_wr_en_o}, 32'd0);
    uart_bus.rx_done_tick_i = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // Fresh load of 32 non-halt words fills memory and ends on its own
    for (int k = 0; k < 32; k++) begin
      load_word(32'h12340000 | k, 7'(4 * k), (k == 31) ? 4'd2 : 4'd0, (k == 31) ? 1'b1 : 1'b0);
    end
    seen = 0;
    for (int b = 0; b < 4; b++) begin
      send_byte(8'h11 + 8'(b));
      if (inst_wr_en_o) seen++;
      tick();
      if (inst_wr_en_o) seen++;
    end
    check("byte33_no_write", seen, 32'd0);
    check("byte33_state", {28'd0, state_o}, 32'd2);

    // Continuous run to halt with a freshly reset counter
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    load_word(32'hFFFFFFFF, 7'd0, 4'd2, 1'b1);
    pc_i = 7'h2C;
    send_byte(8'h43);
    check("run_state", {28'd0, state_o}, 32'd3);
    en_cnt = 0;
    repeat (10) begin
      if (en_pipeline_o) en_cnt++;
      tick();
    end
    halt_i = 1'b1;
    if (en_pipeline_o) en_cnt++;
    tick();
    halt_i = 1'b0;
    check("drain_state", {28'd0, state_o}, 32'd4);
    collect(0, 136, en2, got);
    check("run_en_cycles", en_cnt + en2, 32'd15);
    check("run_len", got, 32'd136);
    check("run_pc", {dump_q[0], dump_q[1], dump_q[2], dump_q[3]}, 32'h0000002C);
    check("run_cnt", {dump_q[4], dump_q[5], dump_q[6], dump_q[7]}, 32'h0000000F);
    check("run_all_bytes", dump_mismatches(got, 32'h0000002C, 32'hF), 32'd0);
    check("run_halted", {31'd0, halted_o}, 32'd1);
    check("run_finished", {28'd0, state_o}, 32'd9);

    // Commands after FINISHED have no effect
    send_byte(8'h43);
    en_cnt = 0;
    seen = 0;
    repeat (8) begin
      if (en_pipeline_o) en_cnt++;
      if (uart_bus.tx_start_o) seen++;
      tick();
    end
    check("finished_no_en", en_cnt, 32'd0);
    check("finished_no_tx", seen, 32'd0);
    check("finished_stays", {28'd0, state_o}, 32'd9);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
